// File: rtl/rv32_pkg.sv
// Shared RV32 execute-side definitions: ALU op codes, datapath widths and the
// operand payload handed from the operand stage to the ALU.
package rv32_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    FOP_ADD = 4'd0,
    FOP_SUB = 4'd1,
    FOP_SLL = 4'd2,
    FOP_SRL = 4'd3,
    FOP_SRA = 4'd4,
    FOP_AND = 4'd5,
    FOP_OR  = 4'd6,
    FOP_XOR = 4'd7,
    FOP_IMM = 4'd8
  } fop_t;

  typedef struct packed {
    logic [XLEN-1:0]    rda;
    logic [XLEN-1:0]    rdb;
    fop_t               fop;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
  } payload_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority forwarding for one source operand: x0, then EX/MEM, then WB, then
// the register file read data.
module operand_fwd_mux
  import rv32_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int AW = RADDR_W
) (
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  rf_data,
  input  logic          ex_valid,
  input  logic [AW-1:0] ex_addr,
  input  logic [W-1:0]  ex_data,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  output logic [W-1:0]  data
);

  // Checking addr==0 first also stops any source that targets x0 from leaking in.
  always_comb begin
    data = rf_data;
    if (addr == '0)
      data = '0;
    else if (ex_valid && (ex_addr == addr))
      data = ex_data;
    else if (wb_valid && (wb_addr == addr))
      data = wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves forwarding and immediate selection at accept
// time, then holds operands in an output register plus a one-entry skid buffer.
module alu_operand_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rs1_addr,
  input  logic [RADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_imm,
  input  logic               in_use_imm,
  input  logic [3:0]         in_fop,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic               in_reg_write,
  input  logic               ex_fwd_valid,
  input  logic [RADDR_W-1:0] ex_fwd_addr,
  input  logic [XLEN-1:0]    ex_fwd_data,
  input  logic               wb_fwd_valid,
  input  logic [RADDR_W-1:0] wb_fwd_addr,
  input  logic [XLEN-1:0]    wb_fwd_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_rda,
  output logic [XLEN-1:0]    out_rdb,
  output logic [3:0]         out_fop,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_reg_write,
  output logic [CNT_W-1:0]   stall_cnt
);
  import rv32_pkg::*;

  // state | meaning
  // EMPTY | nothing held
  // ONE   | output register valid, skid empty
  // FULL  | output register and skid both valid, in_ready low
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  // Local payload so widths follow this module's parameters; fop is kept as raw
  // bits so codes 9-15 pass through untouched.
  typedef struct packed {
    logic [XLEN-1:0]    rda;
    logic [XLEN-1:0]    rdb;
    logic [3:0]         fop;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
  } stage_t;

  logic            out_valid_q;
  logic            skid_valid;
  stage_t          out_q;
  stage_t          skid_q;
  stage_t          in_p;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            accept;

  operand_fwd_mux #(.W(XLEN), .AW(RADDR_W)) u_fwd_rs1 (
    .addr     (in_rs1_addr),
    .rf_data  (in_rs1_data),
    .ex_valid (ex_fwd_valid),
    .ex_addr  (ex_fwd_addr),
    .ex_data  (ex_fwd_data),
    .wb_valid (wb_fwd_valid),
    .wb_addr  (wb_fwd_addr),
    .wb_data  (wb_fwd_data),
    .data     (rs1_val)
  );

  operand_fwd_mux #(.W(XLEN), .AW(RADDR_W)) u_fwd_rs2 (
    .addr     (in_rs2_addr),
    .rf_data  (in_rs2_data),
    .ex_valid (ex_fwd_valid),
    .ex_addr  (ex_fwd_addr),
    .ex_data  (ex_fwd_data),
    .wb_valid (wb_fwd_valid),
    .wb_addr  (wb_fwd_addr),
    .wb_data  (wb_fwd_data),
    .data     (rs2_val)
  );

  always_comb begin
    in_p           = '0;
    in_p.rda       = rs1_val;
    in_p.rdb       = in_use_imm ? in_imm : rs2_val;
    in_p.fop       = in_fop;
    in_p.rd_addr   = in_rd_addr;
    in_p.reg_write = in_reg_write;
  end

  // in_ready depends only on held state, never on out_ready.
  assign in_ready = !rst && !skid_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      skid_valid    <= 1'b0;
      out_q         <= '0;
      out_q.fop     <= FOP_ADD;
      skid_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      case ({out_valid_q, skid_valid})
        ST_EMPTY: begin
          if (accept) begin
            out_q       <= in_p;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept) begin
            if (out_ready) begin
              out_q <= in_p;
            end else begin
              skid_q     <= in_p;
              skid_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_q      <= skid_q;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          skid_valid  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid_q && !out_ready && !flush && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign out_valid     = out_valid_q;
  assign out_rda       = out_q.rda;
  assign out_rdb       = out_q.rdb;
  assign out_fop       = out_q.fop;
  assign out_rd_addr   = out_q.rd_addr;
  assign out_reg_write = out_q.reg_write;

endmodule
